// File: rtl/fetch_controller.sv
// fetch_controller
//   Owns the fetch PC and sequences a combinationally-read 16-bit instruction
//   memory. After reset it reads a two-word reset vector (high word at
//   RST_VEC, low word at RST_VEC+1), then fetches one word per cycle. A word
//   with bit IMM_BIT set is held for one cycle and merged with the following
//   immediate word into a single registered IF/ID record.
//
//   Ports
//     clk           rising-edge clock
//     rst           asynchronous active-high reset
//     mem_addr_o    read address to instruction memory (combinational)
//     mem_data_i    word returned for mem_addr_o
//     stall_i       hold PC, FSM, held word and IF/ID outputs
//     redirect_i    branch/jump taken, refetch from redirect_pc_i
//     redirect_pc_i new fetch address
//     if_valid_o    IF/ID record carries a real instruction
//     if_instr_o    first instruction word
//     if_imm_o      immediate word (0 for one-word instructions)
//     if_pc_o       address of if_instr_o
module fetch_controller #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] RST_VEC = '0,
  parameter int unsigned       IMM_BIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              if_valid_o,
  output logic [15:0]       if_instr_o,
  output logic [15:0]       if_imm_o,
  output logic [ADDR_W-1:0] if_pc_o
);

  typedef enum logic [1:0] {RST_HI, RST_LO, FETCH, FETCH_IMM} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic              vld_q, vld_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  // Reset-vector word placement. Casting to ADDR_W truncates or zero-extends,
  // so narrow PCs simply drop the bits that do not fit (the whole high word
  // when ADDR_W <= 16).
  logic [ADDR_W-1:0] md_w, mask_lo, pc_hi_ld, pc_lo_ld, pc_inc;

  assign md_w     = ADDR_W'(mem_data_i);
  assign mask_lo  = ADDR_W'(16'hFFFF);
  assign pc_hi_ld = (pc_q & mask_lo) | (md_w << 16);
  assign pc_lo_ld = (pc_q & ~mask_lo) | md_w;
  assign pc_inc   = pc_q + ADDR_W'(1);  // wraps silently at all-ones

  always_comb begin
    case (state_q)
      RST_HI:  mem_addr_o = RST_VEC;
      RST_LO:  mem_addr_o = RST_VEC + ADDR_W'(1);
      default: mem_addr_o = pc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    vld_d     = vld_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    ipc_d     = ipc_q;
    case (state_q)
      // stall/redirect are ignored while the vector loads
      RST_HI: begin
        pc_d    = pc_hi_ld;
        state_d = RST_LO;
      end
      RST_LO: begin
        pc_d    = pc_lo_ld;
        state_d = FETCH;
      end
      default: begin
        if (redirect_i) begin
          // a half-fetched two-word instruction is simply abandoned
          pc_d    = redirect_pc_i;
          state_d = FETCH;
          vld_d   = 1'b0;
        end else if (!stall_i) begin
          pc_d = pc_inc;
          if (state_q == FETCH_IMM) begin
            instr_d = hold_q;
            imm_d   = mem_data_i;
            ipc_d   = hold_pc_q;
            vld_d   = 1'b1;
            state_d = FETCH;
          end else if (mem_data_i[IMM_BIT]) begin
            hold_d    = mem_data_i;
            hold_pc_d = pc_q;
            vld_d     = 1'b0;   // bubble while the immediate is read
            state_d   = FETCH_IMM;
          end else begin
            instr_d = mem_data_i;
            imm_d   = '0;
            ipc_d   = pc_q;
            vld_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_HI;
      pc_q      <= '0;
      hold_q    <= '0;
      hold_pc_q <= '0;
      vld_q     <= 1'b0;
      instr_q   <= '0;
      imm_q     <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      vld_q     <= vld_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      ipc_q     <= ipc_d;
    end
  end

  assign if_valid_o = vld_q;
  assign if_instr_o = instr_q;
  assign if_imm_o   = imm_q;
  assign if_pc_o    = ipc_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [15:0] mem_data;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr, if_imm;
  logic [31:0] if_pc;

  // 256-word memory, aliased on the low address byte
  logic [15:0] tbmem [0:255];
  assign mem_data = tbmem[mem_addr[7:0]];

  always #5 clk = ~clk;

  fetch_controller #(.ADDR_W(32), .RST_VEC(32'h0), .IMM_BIT(0)) dut (
    .clk(clk), .rst(rst),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .if_valid_o(if_valid), .if_instr_o(if_instr), .if_imm_o(if_imm),
    .if_pc_o(if_pc)
  );

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [15:0] i,
                         input logic [15:0] m, input logic [31:0] p, input logic [31:0] a);
    chk({tag, " valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, " instr"}, {16'd0, if_instr}, {16'd0, i});
    chk({tag, " imm"},   {16'd0, if_imm},   {16'd0, m});
    chk({tag, " pc"},    if_pc, p);
    chk({tag, " addr"},  mem_addr, a);
  endtask

  // Behavioural model: boot reads two vector words, then walks memory
  // decoding instructions, emitting one record per completed instruction.
  int          m_boot;
  logic [31:0] m_pc, m_hpc;
  logic        m_pend;
  logic [15:0] m_hw;
  logic        m_v;
  logic [15:0] m_i, m_m;
  logic [31:0] m_p;

  function automatic logic [31:0] m_addr();
    if (m_boot == 2) return 32'h0;
    if (m_boot == 1) return 32'h1;
    return m_pc;
  endfunction

  task automatic model_reset();
    m_boot = 2; m_pc = 0; m_pend = 0; m_hw = 0; m_hpc = 0;
    m_v = 0; m_i = 0; m_m = 0; m_p = 0;
  endtask

  task automatic model_edge(input logic st, input logic rd, input logic [31:0] rpc);
    logic [15:0] w;
    w = tbmem[m_addr() & 32'hFF];
    if (m_boot == 2) begin
      m_pc[31:16] = w; m_boot = 1;
    end else if (m_boot == 1) begin
      m_pc[15:0] = w; m_boot = 0;
    end else if (rd) begin
      m_pc = rpc; m_pend = 0; m_v = 0;
    end else if (!st) begin
      if (m_pend) begin
        m_v = 1; m_i = m_hw; m_m = w; m_p = m_hpc; m_pend = 0;
      end else if (w[0]) begin
        m_pend = 1; m_hw = w; m_hpc = m_pc; m_v = 0;
      end else begin
        m_v = 1; m_i = w; m_m = 0; m_p = m_pc;
      end
      m_pc = m_pc + 1;
    end
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        v;
    logic [15:0] ins;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [21];

  initial begin
    // directed program
    for (int k = 0; k < 256; k++) tbmem[k] = 16'h0000;
    tbmem[8'h00] = 16'h0000; tbmem[8'h01] = 16'h0010;
    tbmem[8'h10] = 16'h1230; tbmem[8'h11] = 16'h0001; tbmem[8'h12] = 16'hBEEF;
    tbmem[8'h13] = 16'h4440; tbmem[8'h14] = 16'h5551; tbmem[8'h15] = 16'h6662;
    tbmem[8'h16] = 16'h7770; tbmem[8'h17] = 16'h9991; tbmem[8'h18] = 16'hAAAA;
    tbmem[8'h20] = 16'h2220; tbmem[8'h21] = 16'h3330; tbmem[8'hFF] = 16'h8881;

    //            st rd rpc            v  instr     imm       pc            addr
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 16'h0000, 16'h0000, 32'h0,        32'h1};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 16'h0000, 16'h0000, 32'h0,        32'h10};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h1230, 16'h0000, 32'h10,       32'h11};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 16'h1230, 16'h0000, 32'h10,       32'h12};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h0001, 16'hBEEF, 32'h11,       32'h13};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h4440, 16'h0000, 32'h13,       32'h14};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 16'h4440, 16'h0000, 32'h13,       32'h15};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'h4440, 16'h0000, 32'h13,       32'h15};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'h4440, 16'h0000, 32'h13,       32'h15};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 16'h4440, 16'h0000, 32'h13,       32'h15};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h5551, 16'h6662, 32'h14,       32'h16};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h7770, 16'h0000, 32'h16,       32'h17};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 16'h7770, 16'h0000, 32'h16,       32'h18};
    tbl[13] = '{1'b1, 1'b1, 32'h20,       1'b0, 16'h7770, 16'h0000, 32'h16,       32'h20};
    tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h2220, 16'h0000, 32'h20,       32'h21};
    tbl[15] = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 16'h2220, 16'h0000, 32'h20,       32'hFFFFFFFF};
    tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 16'h2220, 16'h0000, 32'h20,       32'h0};
    tbl[17] = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h8881, 16'h0000, 32'hFFFFFFFF, 32'h1};
    tbl[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h0010, 16'h0000, 32'h1,        32'h2};
    tbl[19] = '{1'b1, 1'b0, 32'h0,        1'b1, 16'h0010, 16'h0000, 32'h1,        32'h2};
    tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 16'h0000, 16'h0000, 32'h2,        32'h3};

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #12 rst = 1'b0;
    #1 chk_all("reset", 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);

    for (int r = 0; r < 21; r++) begin
      stall = tbl[r].st; redirect = tbl[r].rd; redirect_pc = tbl[r].rpc;
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", r), tbl[r].v, tbl[r].ins, tbl[r].imm, tbl[r].pc, tbl[r].addr);
    end

    // async reset while a two-word fetch is pending
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h14;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(posedge clk); #1;
    chk("pend addr", mem_addr, 32'h15);
    chk("pend valid", {31'd0, if_valid}, 32'd0);
    #2 rst = 1'b1;
    #1 chk_all("async rst", 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
    #1 rst = 1'b0;
    // stall/redirect must not disturb the vector load
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h55;
    @(posedge clk); #1;
    chk("reload lo addr", mem_addr, 32'h1);
    @(posedge clk); #1;
    chk("reload vec addr", mem_addr, 32'h10);
    chk("reload valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0; redirect = 1'b0;
    @(posedge clk); #1;
    chk_all("reload first", 1'b1, 16'h1230, 16'h0, 32'h10, 32'h11);

    // randomized run against the model
    rst = 1'b1;
    for (int k = 0; k < 256; k++) tbmem[k] = 16'($urandom);
    #3 rst = 1'b0;
    model_reset();
    stall = 1'b0; redirect = 1'b0;
    for (int n = 0; n < 800; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2))
                                                : $urandom;
      model_edge(stall, redirect, redirect_pc);
      @(posedge clk); #1;
      chk_all("rnd", m_v, m_i, m_m, m_p, m_addr());
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        chk_all("rnd rst", m_v, m_i, m_m, m_p, m_addr());
        #1 rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
